// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the sequential multiply/divide unit.
//   - mdu_op encodings (same values the control unit emits)
//   - FSM state enum
//   - default iteration count
//   - magnitude helper for the signed divide
package mdu_pkg;

    localparam int ITER_DEF = 32;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one combinational iteration of the MDU datapath.
//   is_div  in  1   1 = restoring shift-subtract, 0 = shift-add multiply
//   acc     in  32  partial product high half / partial remainder
//   mq      in  32  multiplier (shifts right) / dividend-quotient (shifts left)
//   opnd    in  32  multiplicand / divisor magnitude
//   acc_nxt out 32  next acc
//   mq_nxt  out 32  next mq
// After 32 steps {acc,mq} holds the 64-bit product, or acc=remainder and
// mq=quotient.
module mdu_iter_step (
    input  logic        is_div,
    input  logic [31:0] acc,
    input  logic [31:0] mq,
    input  logic [31:0] opnd,
    output logic [31:0] acc_nxt,
    output logic [31:0] mq_nxt
);

    logic [32:0] sum;
    logic [32:0] shl;
    logic [31:0] diff;
    logic        ge;

    always_comb begin
        sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : 33'd0);
        // Remainder shifted left with the next dividend bit; needs 33 bits
        // because the remainder can be as large as divisor-1.
        shl  = {acc, mq[31]};
        ge   = (shl >= {1'b0, opnd});
        // When ge holds the true difference is below the divisor, so the
        // low 32 bits are exact.
        diff = shl[31:0] - opnd;
        if (is_div) begin
            acc_nxt = ge ? diff : shl[31:0];
            mq_nxt  = {mq[30:0], ge};
        end else begin
            acc_nxt = sum[32:1];
            mq_nxt  = {sum[0], mq[31:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit with architectural HI/LO.
//   clk, rst_n      clock, async active-low reset
//   op_valid        current instruction carries an MDU op
//   mdu_op[2:0]     0 none, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   rs_data, rt_data  operands (rs also the source of mthi/mtlo)
//   stall           hold PC/instruction
//   busy, done      BUSY state / one-cycle DONE pulse
//   hi, lo          HI/LO registers
// Optional: MDU_MULTU_FAST_EN makes multu a single-edge combinational
// multiply with no stall; divides are always iterative.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          is_div_q, q_neg_q, r_neg_q;
    logic [31:0]   acc_q, mq_q, opnd_q;
    logic [31:0]   acc_nxt, mq_nxt;
    logic [31:0]   hi_q, lo_q;

    logic [2:0] op_sel;
    logic       is_mul, is_dv, div_zero, long_op;
    logic       start, dz_load, finish, mv_hi, mv_lo;

    // Unknown codes collapse to none.
    always_comb begin
        op_sel   = op_valid ? mdu_op : MDU_NONE;
        is_mul   = (op_sel == MDU_MULTU);
        is_dv    = (op_sel == MDU_DIV) || (op_sel == MDU_DIVU);
        div_zero = is_dv && (rt_data == 32'd0);
`ifdef MDU_MULTU_FAST_EN
        long_op  = is_dv;
`else
        long_op  = is_dv || is_mul;
`endif
    end

`ifdef MDU_MULTU_FAST_EN
    logic        fast_mul;
    logic [63:0] prod;
    assign prod = 64'(rs_data) * 64'(rt_data);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        start   = 1'b0;
        dz_load = 1'b0;
        finish  = 1'b0;
        mv_hi   = 1'b0;
        mv_lo   = 1'b0;
`ifdef MDU_MULTU_FAST_EN
        fast_mul = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (long_op) begin
                    stall = 1'b1;
                    // Divide by zero skips iteration: result lands at this edge.
                    if (div_zero) begin
                        dz_load = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        start   = 1'b1;
                        state_d = ST_BUSY;
                    end
                end else if (op_sel == MDU_MTHI) begin
                    mv_hi = 1'b1;
                end else if (op_sel == MDU_MTLO) begin
                    mv_lo = 1'b1;
                end
`ifdef MDU_MULTU_FAST_EN
                else if (is_mul) begin
                    fast_mul = 1'b1;
                end
`endif
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (cnt_q == LAST) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            // The instruction still presented here is the one just executed;
            // op_valid is ignored so it cannot restart.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    assign done = (state_q == ST_DONE);

    mdu_iter_step u_step (
        .is_div  (is_div_q),
        .acc     (acc_q),
        .mq      (mq_q),
        .opnd    (opnd_q),
        .acc_nxt (acc_nxt),
        .mq_nxt  (mq_nxt)
    );

    // Operand/iteration registers. Loaded only on the accept edge, so input
    // changes during BUSY are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
        end else if (start) begin
            cnt_q    <= '0;
            is_div_q <= is_dv;
            q_neg_q  <= (op_sel == MDU_DIV) && (rs_data[31] ^ rt_data[31]);
            r_neg_q  <= (op_sel == MDU_DIV) && rs_data[31];
            acc_q    <= '0;
            if (op_sel == MDU_DIV) begin
                mq_q   <= mag32(rs_data);
                opnd_q <= mag32(rt_data);
            end else if (is_dv) begin
                mq_q   <= rs_data;
                opnd_q <= rt_data;
            end else begin
                mq_q   <= rt_data;
                opnd_q <= rs_data;
            end
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_nxt;
            mq_q  <= mq_nxt;
        end
    end

    // HI/LO: written only by a completed op, divide-by-zero or a move, so a
    // reset mid-iteration leaves no partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (dz_load) begin
            hi_q <= rs_data;
            lo_q <= 32'hFFFF_FFFF;
        end else if (finish) begin
            if (is_div_q) begin
                lo_q <= q_neg_q ? (~mq_nxt + 32'd1)  : mq_nxt;
                hi_q <= r_neg_q ? (~acc_nxt + 32'd1) : acc_nxt;
            end else begin
                hi_q <= acc_nxt;
                lo_q <= mq_nxt;
            end
        end else if (mv_hi) begin
            hi_q <= rs_data;
        end else if (mv_lo) begin
            lo_q <= rs_data;
        end
`ifdef MDU_MULTU_FAST_EN
        else if (fast_mul) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
        end
`endif
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
